// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader streaming a program image into CPU RAM while holding the CPU in reset
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing 8-bit modular-sum byte.
module program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_RELEASE,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                w_hs;
  logic                w_restart;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   r_sum;
`endif

  assign w_hs      = in_valid & in_ready;
  assign w_restart = start & ((r_state == S_IDLE) | (r_state == S_RUN) | (r_state == S_ERROR));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        if (w_hs && (r_cnt == LAST_ADDR)) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = S_RELEASE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_hs) w_next = (in_data == r_sum) ? S_RELEASE : S_ERROR;
      end
`endif
      S_RELEASE: w_next = S_RUN;
      default:   w_next = S_IDLE;
    endcase
  end

  // in_ready is a pure decode of the registered state so it never combinationally follows in_valid
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_hold = 1'b1;
    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_RELEASE: busy = 1'b1;
      S_RUN: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      S_ERROR: err = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      if (w_restart) begin
        r_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
        r_sum <= '0;
`endif
      end else if ((r_state == S_LOAD) && w_hs) begin
        r_wr_en <= 1'b1;
        r_addr  <= r_cnt;
        r_data  <= in_data;
        r_cnt   <= r_cnt + ADDR_ONE;
`ifdef LOADER_CHECKSUM_EN
        r_sum   <= r_sum + in_data;
`endif
      end
    end
  end

  assign ram_wr_en = r_wr_en;
  assign ram_addr  = r_addr;
  assign ram_data  = r_data;

endmodule

// File: doc/program_loader.md
# program_loader

Upstream boot stage for the 8-bit CPU. It accepts a 16-byte program image over a valid/ready byte stream and writes it into the CPU's 16×8 RAM through the RAM write port. It holds the CPU in reset while loading and releases it once the image is committed. The CPU then starts from PC = 0 against a fully written memory.

## Interface
Parameters:
- ADDR_W, 4, RAM address width; image length DEPTH = 2**ADDR_W bytes
- DATA_W, 8, RAM/stream data width

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- start  in  1  pulse: begin (re)load
- in_valid  in  1  stream byte valid
- in_data  in  DATA_W  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- ram_wr_en  out  1  RAM write strobe, one cycle per byte
- ram_addr  out  ADDR_W  RAM write address
- ram_data  out  DATA_W  RAM write data
- cpu_hold  out  1  active-high; top level maps it onto the CPU's reset
- busy  out  1  load in progress
- done  out  1  image loaded, CPU running
- err  out  1  checksum mismatch (tied 0 without LOADER_CHECKSUM_EN)

## Operation
- States: IDLE, LOAD, CHECK (checksum build only), RELEASE, RUN, ERROR.
- Reset (rst=0 at posedge) values:
  - State = IDLE.
  - cpu_hold=1.
  - in_ready=0, ram_wr_en=0, ram_addr=0, ram_data=0.
  - busy=0, done=0, err=0.
  - Internal address counter and checksum accumulator = 0.
- IDLE: cpu_hold=1. On start: go to LOAD, counter=0, sum=0.
- LOAD:
  - in_ready=1, busy=1.
  - Handshake (in_valid & in_ready at a posedge) registers ram_wr_en=1, ram_addr=counter, ram_data=in_data, sum += in_data (mod 2^DATA_W), counter++.
  - ram_wr_en is 0 in every cycle without a handshake.
  - After the handshake at counter = DEPTH-1, go to CHECK if LOADER_CHECKSUM_EN is defined, else RELEASE. The counter wraps to 0 and is not used further.
- CHECK:
  - in_ready=1.
  - One byte is accepted and not written to RAM.
  - If it equals sum, go to RELEASE; otherwise go to ERROR.
- RELEASE: single cycle, cpu_hold still 1, in_ready=0. Always goes to RUN.
- RUN: cpu_hold=0, done=1, busy=0. On start: go to LOAD, done=0, cpu_hold=1 on the next cycle.
- ERROR: cpu_hold=1, err=1. On start: go to LOAD and clear err.
- start while in LOAD, CHECK or RELEASE is ignored.
- in_data is ignored whenever in_ready=0. A source holding in_valid through IDLE is not consumed.
- Reset mid-load: returns to IDLE immediately. RAM contents written so far remain, because the RAM has no reset. The CPU stays held.

## Timing
- in_ready depends only on state (registered), never on in_valid.
- Write latency: handshake at posedge N gives ram_wr_en/addr/data valid during cycle N+1. The RAM captures the data at posedge N+2.
- Back-to-back bytes are accepted every cycle. Minimum load time without checksum is DEPTH cycles.
- Last data byte handshake at N (no checksum):
  - RELEASE during N+1, carrying the final write.
  - RUN from N+2, with cpu_hold=0 and done=1.
  - The CPU never sees cpu_hold low before its last RAM write completes.
- Checksum byte handshake at M:
  - Match: RELEASE during M+1, cpu_hold low and done high from M+2.
  - Mismatch: err high from M+1.
- start in RUN at posedge K: cpu_hold=1, done=0 and in_ready=1 from K+1.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - CHECK state and the checksum accumulator are compiled in.
  - The image is DEPTH+1 bytes: the last byte is the 8-bit modular sum of the DEPTH program bytes.
  - err is live.
- LOADER_CHECKSUM_EN undefined:
  - No CHECK, no accumulator; LOAD goes straight to RELEASE.
  - ERROR is unreachable and err is constant 0.

## Test plan
- Reset then idle: hold rst=0 for 2 cycles, then rst=1 with no start. Required: cpu_hold=1, in_ready=0, ram_wr_en never high, done=0.
- Full-rate load, no checksum: start, then stream 0x00..0x0F with in_valid held high. Required:
  - 16 ram_wr_en pulses at addr 0..15 with data equal to addr.
  - cpu_hold falls exactly 2 cycles after the 16th handshake.
  - done=1.
- Stalled stream: same image with in_valid toggled 1,0,0,1,… Required: RAM writes only on handshake cycles, addresses contiguous, final RAM image identical to the full-rate case.
- Checksum pass/fail (LOADER_CHECKSUM_EN):
  - Bytes 0x01..0x10 then 0x88 (the correct sum): RUN, done=1, err=0.
  - Same bytes then 0x87: ERROR, err=1, cpu_hold=1.
  - A subsequent start and correct reload clears err and reaches RUN.
- Reset mid-load: rst=0 after the 7th handshake. Required: IDLE, ram_wr_en=0, cpu_hold=1. A new start writes from addr 0 again.
- Reload from RUN and ignored start: start in RUN reasserts cpu_hold the next cycle. A start pulse during LOAD leaves the counter unchanged and does not disturb the write sequence.
